// File: rtl/riscv_aes_ctx_pkg.sv
`default_nettype none
// riscv_aes_ctx_pkg: shared types and helpers for the AES context register file.
// Rev 1.0
package riscv_aes_ctx_pkg;

  typedef enum logic [1:0] {
    KL128 = 2'd0,
    KL192 = 2'd1,
    KL256 = 2'd2
  } key_len_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    BUSY    = 2'd2,
    CAPTURE = 2'd3
  } fsm_e;

  localparam logic WSEL_STATE = 1'b0;
  localparam logic WSEL_KEY   = 1'b1;

  // Zero marks an illegal encoding; callers reject it before use.
  function automatic int key_len_words(input key_len_e kl);
    case (kl)
      KL128:   return 4;
      KL192:   return 6;
      KL256:   return 8;
      default: return 0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_aes_ctx_regfile_key_bank.sv
`default_nettype none
// riscv_aes_key_bank: KEY_SLOTS x KEY_WORDS key storage with per-word valid bits.
// Rev 1.0
module riscv_aes_key_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int KEY_WORDS  = 8,
  parameter int KEY_SLOTS  = 4,
  localparam int AW = $clog2(KEY_WORDS),
  localparam int SW = $clog2(KEY_SLOTS),
  localparam int BE = DATA_WIDTH / 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wen_i,
  input  logic                            clr_i,
  input  logic                            lock_i,
  input  logic [SW-1:0]                   slot_i,
  input  logic [AW-1:0]                   addr_i,
  input  logic [BE-1:0]                   be_i,
  input  logic [DATA_WIDTH-1:0]           data_i,
  output logic                            err_o,
  input  logic [SW-1:0]                   act_slot_i,
  output logic [KEY_WORDS*DATA_WIDTH-1:0] act_key_o,
  input  logic [SW-1:0]                   chk_slot_i,
  output logic [KEY_WORDS-1:0]            chk_valid_o,
  input  logic [SW-1:0]                   rd_slot_i,
  input  logic [AW-1:0]                   rd_addr_i,
  output logic [DATA_WIDTH-1:0]           rd_word_o
);

  logic [DATA_WIDTH-1:0] key_q    [KEY_SLOTS][KEY_WORDS];
  logic [DATA_WIDTH-1:0] key_d    [KEY_SLOTS][KEY_WORDS];
  logic [KEY_WORDS-1:0]  kvalid_q [KEY_SLOTS];
  logic [KEY_WORDS-1:0]  kvalid_d [KEY_SLOTS];

  always_comb begin
    key_d    = key_q;
    kvalid_d = kvalid_q;
    err_o    = 1'b0;
    // A clear always swallows a coincident write.
    if (clr_i) begin
      if (lock_i) begin
        err_o = 1'b1;
      end else begin
        for (int s = 0; s < KEY_SLOTS; s++) begin
          if (int'(slot_i) == s) begin
            for (int w = 0; w < KEY_WORDS; w++) key_d[s][w] = '0;
            kvalid_d[s] = '0;
          end
        end
      end
    end else if (wen_i) begin
      if (lock_i || int'(addr_i) >= KEY_WORDS) begin
        err_o = 1'b1;
      end else begin
        for (int s = 0; s < KEY_SLOTS; s++) begin
          for (int w = 0; w < KEY_WORDS; w++) begin
            if (int'(slot_i) == s && int'(addr_i) == w) begin
              for (int b = 0; b < BE; b++) begin
                if (be_i[b]) key_d[s][w][b*8 +: 8] = data_i[b*8 +: 8];
              end
              kvalid_d[s][w] = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q    <= '{default: '0};
      kvalid_q <= '{default: '0};
    end else begin
      key_q    <= key_d;
      kvalid_q <= kvalid_d;
    end
  end

  for (genvar w = 0; w < KEY_WORDS; w++) begin : g_act_key
    assign act_key_o[w*DATA_WIDTH +: DATA_WIDTH] = key_q[act_slot_i][w];
  end

  assign chk_valid_o = kvalid_q[chk_slot_i];

  always_comb begin
    rd_word_o = '0;
    for (int s = 0; s < KEY_SLOTS; s++) begin
      for (int w = 0; w < KEY_WORDS; w++) begin
        if (int'(rd_slot_i) == s && int'(rd_addr_i) == w) rd_word_o = key_q[s][w];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/riscv_aes_ctx_regfile.sv
`default_nettype none
// riscv_aes_ctx_regfile: AES state/key context with engine launch and result capture.
// Rev 1.0
module riscv_aes_ctx_regfile
  import riscv_aes_ctx_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int STATE_WORDS = 4,
  parameter int KEY_WORDS   = 8,
  parameter int KEY_SLOTS   = 4,
  localparam int AW = $clog2(KEY_WORDS),
  localparam int SW = $clog2(KEY_SLOTS),
  localparam int BE = DATA_WIDTH / 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              test_en_i,
  input  logic                              wen_i,
  input  logic                              wsel_i,
  input  logic [SW-1:0]                     wslot_i,
  input  logic [AW-1:0]                     waddr_i,
  input  logic [BE-1:0]                     wbe_i,
  input  logic [DATA_WIDTH-1:0]             wdata_i,
  input  logic                              kclr_i,
  output logic                              werr_o,
  input  logic                              start_i,
  input  logic [SW-1:0]                     start_slot_i,
  input  logic [1:0]                        key_len_i,
  output logic                              start_err_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              eng_start_o,
  output logic [1:0]                        eng_key_len_o,
  output logic [STATE_WORDS*DATA_WIDTH-1:0] eng_state_o,
  output logic [KEY_WORDS*DATA_WIDTH-1:0]   eng_key_o,
  input  logic                              eng_done_i,
  input  logic [STATE_WORDS*DATA_WIDTH-1:0] eng_result_i,
  input  logic                              rsel_i,
  input  logic [SW-1:0]                     rslot_i,
  input  logic [AW-1:0]                     raddr_i,
  output logic [DATA_WIDTH-1:0]             rdata_o
);

  fsm_e                  fsm_q, fsm_d;
  logic [DATA_WIDTH-1:0] state_q [STATE_WORDS];
  logic [DATA_WIDTH-1:0] state_d [STATE_WORDS];
  logic [SW-1:0]         slot_q, slot_d;
  logic [1:0]            klen_q, klen_d;
  logic                  done_q, done_d;
  logic                  werr_q, werr_d;
  logic                  start_err_q, start_err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  busy;
  logic                  start_acc;
  logic                  kv_ok;
  int                    n_words;
  logic                  st_wr;
  logic                  st_err;
  logic                  key_lock;
  logic                  bank_err;
  logic [KEY_WORDS-1:0]  chk_valid;
  logic [DATA_WIDTH-1:0] key_rd_word;

  assign busy = (fsm_q != IDLE);

  always_comb begin
    n_words = key_len_words(key_len_e'(key_len_i));
    kv_ok   = 1'b1;
    for (int i = 0; i < KEY_WORDS; i++) begin
      if (i < n_words && !chk_valid[i]) kv_ok = 1'b0;
    end
    start_acc = start_i && (fsm_q == IDLE) && (key_len_i != 2'd3) &&
                (n_words <= KEY_WORDS) && kv_ok;
    // The slot being launched this cycle is locked just like the in-flight one.
    key_lock  = (busy && (wslot_i == slot_q)) ||
                (start_acc && (wslot_i == start_slot_i));
  end

  riscv_aes_key_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .KEY_WORDS  (KEY_WORDS),
    .KEY_SLOTS  (KEY_SLOTS)
  ) u_key_bank (
    .clk         (clk),
    .rst         (rst),
    .wen_i       (wen_i && (wsel_i == WSEL_KEY)),
    .clr_i       (kclr_i),
    .lock_i      (key_lock),
    .slot_i      (wslot_i),
    .addr_i      (waddr_i),
    .be_i        (wbe_i),
    .data_i      (wdata_i),
    .err_o       (bank_err),
    .act_slot_i  (slot_q),
    .act_key_o   (eng_key_o),
    .chk_slot_i  (start_slot_i),
    .chk_valid_o (chk_valid),
    .rd_slot_i   (rslot_i),
    .rd_addr_i   (raddr_i),
    .rd_word_o   (key_rd_word)
  );

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    slot_d      = slot_q;
    klen_d      = klen_q;
    done_d      = done_q;
    start_err_d = start_i && !start_acc;
    st_err      = 1'b0;
    st_wr       = wen_i && (wsel_i == WSEL_STATE) && !kclr_i;

    if (test_en_i && !busy) begin
      for (int w = 0; w < STATE_WORDS; w++) state_d[w] = '1;
    end else if (st_wr) begin
      if (busy || start_acc || int'(waddr_i) >= STATE_WORDS) begin
        st_err = 1'b1;
      end else begin
        for (int w = 0; w < STATE_WORDS; w++) begin
          if (int'(waddr_i) == w) begin
            for (int b = 0; b < BE; b++) begin
              if (wbe_i[b]) state_d[w][b*8 +: 8] = wdata_i[b*8 +: 8];
            end
          end
        end
        done_d = 1'b0;
      end
    end
    werr_d = st_err || bank_err;

    case (fsm_q)
      IDLE: begin
        if (start_acc) begin
          fsm_d  = LAUNCH;
          slot_d = start_slot_i;
          klen_d = key_len_i;
          done_d = 1'b0;
        end
      end
      LAUNCH: fsm_d = BUSY;
      BUSY: begin
        if (eng_done_i) begin
          fsm_d = CAPTURE;
          for (int w = 0; w < STATE_WORDS; w++) begin
            state_d[w] = eng_result_i[w*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
      CAPTURE: begin
        fsm_d  = IDLE;
        done_d = 1'b1;
      end
      default: fsm_d = IDLE;
    endcase

    rdata_d = '0;
    if (rsel_i == WSEL_KEY) begin
      rdata_d = key_rd_word;
    end else begin
      for (int w = 0; w < STATE_WORDS; w++) begin
        if (int'(raddr_i) == w) rdata_d = state_q[w];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      state_q     <= '{default: '0};
      slot_q      <= '0;
      klen_q      <= '0;
      done_q      <= 1'b0;
      werr_q      <= 1'b0;
      start_err_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      slot_q      <= slot_d;
      klen_q      <= klen_d;
      done_q      <= done_d;
      werr_q      <= werr_d;
      start_err_q <= start_err_d;
      rdata_q     <= rdata_d;
    end
  end

  for (genvar w = 0; w < STATE_WORDS; w++) begin : g_state_out
    assign eng_state_o[w*DATA_WIDTH +: DATA_WIDTH] = state_q[w];
  end

  assign busy_o        = busy;
  assign eng_start_o   = (fsm_q == LAUNCH);
  assign eng_key_len_o = klen_q;
  assign done_o        = done_q;
  assign werr_o        = werr_q;
  assign start_err_o   = start_err_q;
  assign rdata_o       = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_aes_ctx_regfile.sv
`default_nettype none
// tb_riscv_aes_ctx_regfile: directed and random checks against a word-level context model.
// Rev 1.0
module tb_riscv_aes_ctx_regfile;

  localparam int NS = 4;
  localparam int NK = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         test_en_i, wen_i, wsel_i, kclr_i, start_i, eng_done_i, rsel_i;
  logic [1:0]   wslot_i, start_slot_i, key_len_i, rslot_i;
  logic [2:0]   waddr_i, raddr_i;
  logic [3:0]   wbe_i;
  logic [31:0]  wdata_i;
  logic         werr_o, start_err_o, busy_o, done_o, eng_start_o;
  logic [1:0]   eng_key_len_o;
  logic [127:0] eng_state_o, eng_result_i;
  logic [255:0] eng_key_o;
  logic [31:0]  rdata_o;

  always #5 clk = ~clk;

  riscv_aes_ctx_regfile dut (
    .clk(clk), .rst(rst), .test_en_i(test_en_i), .wen_i(wen_i), .wsel_i(wsel_i),
    .wslot_i(wslot_i), .waddr_i(waddr_i), .wbe_i(wbe_i), .wdata_i(wdata_i),
    .kclr_i(kclr_i), .werr_o(werr_o), .start_i(start_i), .start_slot_i(start_slot_i),
    .key_len_i(key_len_i), .start_err_o(start_err_o), .busy_o(busy_o), .done_o(done_o),
    .eng_start_o(eng_start_o), .eng_key_len_o(eng_key_len_o), .eng_state_o(eng_state_o),
    .eng_key_o(eng_key_o), .eng_done_i(eng_done_i), .eng_result_i(eng_result_i),
    .rsel_i(rsel_i), .rslot_i(rslot_i), .raddr_i(raddr_i), .rdata_o(rdata_o)
  );

  int total = 0;
  int bad   = 0;
  int launches = 0;

  always @(posedge clk) if (eng_start_o === 1'b1) launches <= launches + 1;

  logic [31:0] m_state [NS];
  logic [31:0] m_key   [4][NK];
  bit          m_kv    [4][NK];
  bit          m_busy, m_done;
  int          m_slot;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] m_state_flat();
    logic [127:0] v;
    for (int i = 0; i < NS; i++) v[i*32 +: 32] = m_state[i];
    return v;
  endfunction

  function automatic logic [255:0] m_key_flat(input int s);
    logic [255:0] v;
    for (int i = 0; i < NK; i++) v[i*32 +: 32] = m_key[s][i];
    return v;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                        input logic [31:0] d);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic m_reset();
    for (int s = 0; s < 4; s++)
      for (int w = 0; w < NK; w++) begin
        m_key[s][w] = '0;
        m_kv[s][w]  = 1'b0;
      end
    for (int w = 0; w < NS; w++) m_state[w] = '0;
    m_busy = 1'b0;
    m_done = 1'b0;
    m_slot = 0;
  endtask

  task automatic wr(input bit sel, input int slot, input int addr, input logic [3:0] be,
                    input logic [31:0] d, input string tag);
    bit ok;
    wen_i = 1'b1; wsel_i = sel; wslot_i = slot[1:0]; waddr_i = addr[2:0];
    wbe_i = be; wdata_i = d;
    if (!sel) ok = !m_busy && (addr < NS);
    else      ok = !(m_busy && slot == m_slot);
    tick();
    wen_i = 1'b0;
    if (ok) begin
      if (!sel) begin
        m_state[addr] = merge(m_state[addr], be, d);
        m_done = 1'b0;
      end else begin
        m_key[slot][addr] = merge(m_key[slot][addr], be, d);
        m_kv[slot][addr]  = 1'b1;
      end
    end
    chk({tag, " werr"}, werr_o, !ok);
  endtask

  task automatic kclr(input int slot, input bit with_wr, input string tag);
    bit ok;
    kclr_i = 1'b1; wslot_i = slot[1:0];
    wen_i = with_wr; wsel_i = 1'b1; waddr_i = 3'd2; wbe_i = 4'hf; wdata_i = $urandom;
    ok = !(m_busy && slot == m_slot);
    tick();
    kclr_i = 1'b0; wen_i = 1'b0;
    if (ok)
      for (int w = 0; w < NK; w++) begin
        m_key[slot][w] = '0;
        m_kv[slot][w]  = 1'b0;
      end
    chk({tag, " werr"}, werr_o, !ok);
  endtask

  task automatic start(input int slot, input int kl, input bit swr, input string tag);
    int n;
    bit ok, rej;
    logic [31:0] wd;
    n  = (kl == 0) ? 4 : (kl == 1) ? 6 : (kl == 2) ? 8 : 0;
    ok = !m_busy && (kl != 3) && (n <= NK);
    for (int i = 0; i < n; i++) if (!m_kv[slot][i]) ok = 1'b0;
    wd = $urandom;
    start_i = 1'b1; start_slot_i = slot[1:0]; key_len_i = kl[1:0];
    if (swr) begin
      wen_i = 1'b1; wsel_i = 1'b0; waddr_i = 3'd0; wbe_i = 4'hf; wdata_i = wd;
    end
    tick();
    start_i = 1'b0; wen_i = 1'b0;
    chk({tag, " start_err"}, start_err_o, !ok);
    if (swr) begin
      rej = ok || m_busy;
      chk({tag, " same-cycle werr"}, werr_o, rej);
      if (!rej) begin
        m_state[0] = wd;
        m_done = 1'b0;
      end
    end
    if (ok) begin
      m_busy = 1'b1;
      m_slot = slot;
      m_done = 1'b0;
      chk({tag, " eng_start"}, eng_start_o, 1'b1);
      chk({tag, " key_len"}, eng_key_len_o, kl);
      chk({tag, " eng_key"}, eng_key_o, m_key_flat(slot));
    end
    chk({tag, " busy"}, busy_o, m_busy);
    chk({tag, " done"}, done_o, m_done);
  endtask

  task automatic finish_op(input logic [127:0] res, input int delay, input string tag);
    for (int i = 0; i < delay; i++) tick();
    eng_done_i = 1'b1; eng_result_i = res;
    tick();
    eng_done_i = 1'b0;
    chk({tag, " capture busy"}, busy_o, 1'b1);
    chk({tag, " capture state"}, eng_state_o, res);
    tick();
    m_busy = 1'b0;
    m_done = 1'b1;
    for (int w = 0; w < NS; w++) m_state[w] = res[w*32 +: 32];
    chk({tag, " idle busy"}, busy_o, 1'b0);
    chk({tag, " done"}, done_o, 1'b1);
  endtask

  task automatic rd(input bit sel, input int slot, input int addr, input string tag);
    logic [31:0] exp;
    rsel_i = sel; rslot_i = slot[1:0]; raddr_i = addr[2:0];
    if (sel) exp = m_key[slot][addr];
    else     exp = (addr < NS) ? m_state[addr] : 32'h0;
    tick();
    chk(tag, rdata_o, exp);
  endtask

  initial begin
    int base;
    logic [127:0] fips_res;
    logic [31:0]  fk [4];
    logic [31:0]  fs [4];

    rst = 1'b1; test_en_i = 0; wen_i = 0; wsel_i = 0; kclr_i = 0; start_i = 0;
    eng_done_i = 0; rsel_i = 0; wslot_i = 0; start_slot_i = 0; key_len_i = 0;
    rslot_i = 0; waddr_i = 0; raddr_i = 0; wbe_i = 0; wdata_i = 0; eng_result_i = '0;
    m_reset();
    tick(); tick();
    rst = 1'b0;
    chk("reset busy", busy_o, 1'b0);
    chk("reset done", done_o, 1'b0);
    chk("reset werr", werr_o, 1'b0);
    chk("reset start_err", start_err_o, 1'b0);
    chk("reset eng_start", eng_start_o, 1'b0);
    chk("reset state", eng_state_o, '0);
    chk("reset key", eng_key_o, '0);
    chk("reset rdata", rdata_o, '0);

    // FIPS-197 AES-128 vector on slot 1
    fk = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
    fs = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
    fips_res = {32'h70b4c55a, 32'hd8cdb780, 32'h6a7b0430, 32'h69c4e0d8};
    for (int w = 0; w < 4; w++) wr(1'b1, 1, w, 4'hf, fk[w], "fips key");
    for (int w = 0; w < 4; w++) wr(1'b0, 0, w, 4'hf, fs[w], "fips state");
    chk("fips state loaded", eng_state_o, m_state_flat());
    base = launches;
    start(1, 0, 1'b0, "fips");
    finish_op(fips_res, 10, "fips");
    chk("fips launches", launches - base, 1);
    chk("fips result", eng_state_o, fips_res);

    // Partial key: only words 0-3 of slot 2 valid
    for (int w = 0; w < 4; w++) wr(1'b1, 2, w, 4'hf, $urandom, "partial key");
    start(2, 2, 1'b0, "partial reject");
    start(2, 3, 1'b0, "illegal klen");
    for (int w = 4; w < 8; w++) wr(1'b1, 2, w, 4'hf, $urandom, "partial key hi");
    start(2, 2, 1'b1, "partial accept");
    finish_op({$urandom, $urandom, $urandom, $urandom}, 2, "partial");

    // Lock while busy on slot 0
    for (int w = 0; w < 4; w++) wr(1'b1, 0, w, 4'hf, $urandom, "lock key");
    start(0, 0, 1'b0, "lock");
    wr(1'b0, 0, 0, 4'hf, $urandom, "lock state wr");
    chk("lock state unchanged", eng_state_o, m_state_flat());
    wr(1'b1, 0, 3, 4'hf, $urandom, "lock slot0 wr");
    wr(1'b1, 3, 3, 4'hf, 32'h5a5a1234, "lock slot3 wr");
    kclr(0, 1'b0, "lock clr");
    start(1, 0, 1'b0, "start while busy");
    rd(1'b1, 0, 3, "lock slot0 rd");
    rd(1'b1, 3, 3, "lock slot3 rd");
    finish_op({$urandom, $urandom, $urandom, $urandom}, 3, "lock");

    // Byte enables and validity from a partial write
    wr(1'b1, 3, 4, 4'hf, 32'hAABBCCDD, "be init");
    wr(1'b1, 3, 4, 4'b0101, 32'h11223344, "be merge");
    rd(1'b1, 3, 4, "be model rd");
    chk("be const", rdata_o, 32'hAA22CC44);
    kclr(3, 1'b0, "be clr");
    for (int w = 1; w < 4; w++) wr(1'b1, 3, w, 4'hf, $urandom, "be fill");
    wr(1'b1, 3, 0, 4'b0101, 32'h11223344, "be partial");
    start(3, 0, 1'b0, "be valid start");
    finish_op({$urandom, $urandom, $urandom, $urandom}, 1, "be");

    // Clear and write in the same cycle on slot 1
    kclr(1, 1'b1, "clr+wr");
    rd(1'b1, 1, 0, "clr rd0");
    rd(1'b1, 1, 2, "clr rd2");
    start(1, 0, 1'b0, "clr start");

    // Random writes, clears and readbacks
    for (int i = 0; i < 40; i++) begin
      if (i % 10 == 9) kclr($urandom_range(0, 3), $urandom_range(0, 1), "rand clr");
      else wr($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 7),
              4'($urandom), $urandom, "rand wr");
    end
    for (int i = 0; i < 20; i++)
      rd($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 7), "rand rd");
    chk("rand state", eng_state_o, m_state_flat());
    chk("rand done", done_o, m_done);

    // Test mode forces all-ones state
    test_en_i = 1'b1;
    tick();
    test_en_i = 1'b0;
    for (int w = 0; w < NS; w++) m_state[w] = '1;
    chk("test_en state", eng_state_o, m_state_flat());

    // Reset in the middle of an operation
    for (int w = 0; w < 4; w++) wr(1'b1, 0, w, 4'hf, $urandom, "rst key");
    start(0, 0, 1'b0, "rst op");
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_reset();
    chk("rst busy", busy_o, 1'b0);
    chk("rst done", done_o, 1'b0);
    chk("rst state", eng_state_o, '0);
    chk("rst eng_start", eng_start_o, 1'b0);
    eng_done_i = 1'b1; eng_result_i = {$urandom, $urandom, $urandom, $urandom};
    tick();
    eng_done_i = 1'b0;
    chk("late done busy", busy_o, 1'b0);
    chk("late done state", eng_state_o, '0);
    tick();
    chk("late done done", done_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
